// File: rtl/board_pkg.sv
// Shared types and colour constants for the board renderer.
package board_pkg;
  typedef enum logic [2:0] {BG, BORDER, GRID, CELL, BLANK} region_e;

  localparam logic [11:0] WHITE = 12'hFFF;
  localparam logic [11:0] BLACK = 12'h000;

  // Index 0 is the empty-field colour, 1-7 are the piece colours.
  localparam logic [7:0][11:0] PALETTE = {
    12'hF00, 12'hA0F, 12'h0F0, 12'hAA0, 12'hF80, 12'h00F, 12'h0FF, 12'hFF0
  };

  function automatic logic [11:0] pal_rgb(input logic [2:0] idx);
    return PALETTE[idx];
  endfunction
endpackage

// File: rtl/board_renderer_if.sv
// Video-timing, board-write and pixel-out signals between game/timing logic and the renderer.
interface board_renderer_if #(
  parameter int COLS = 10,
  parameter int ROWS = 20
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  logic            pix_en;
  logic [9:0]      counter_x;
  logic [9:0]      counter_y;
  logic            video_on;
  logic            frame_start;
  logic            wr_en;
  logic [CW-1:0]   wr_col;
  logic [RW-1:0]   wr_row;
  logic [2:0]      wr_data;
  logic            commit;
  logic [ROWS-1:0] flash_mask;
  logic            commit_pending;
  logic [3:0]      r_red;
  logic [3:0]      r_green;
  logic [3:0]      r_blue;

  modport master (
    output pix_en, counter_x, counter_y, video_on, frame_start,
    output wr_en, wr_col, wr_row, wr_data, commit, flash_mask,
    input  commit_pending, r_red, r_green, r_blue
  );
  modport slave (
    input  pix_en, counter_x, counter_y, video_on, frame_start,
    input  wr_en, wr_col, wr_row, wr_data, commit, flash_mask,
    output commit_pending, r_red, r_green, r_blue
  );
endinterface

// File: rtl/board_tracker.sv
// Per-axis cell index + sub-pixel counter; replaces a divide by the cell size.
module board_tracker #(
  parameter int CELL = 20,
  parameter int IW   = 4,
  parameter int SW   = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic          i_adv,
  output logic [IW-1:0] o_idx,
  output logic [SW-1:0] o_sub
);
  logic [IW-1:0] r_idx;
  logic [SW-1:0] r_sub;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_sub <= '0;
    end else if (i_load) begin
      r_idx <= '0;
      r_sub <= '0;
    end else if (i_adv) begin
      if (r_sub == SW'(CELL - 1)) begin
        r_sub <= '0;
        r_idx <= r_idx + 1'b1;
      end else begin
        r_sub <= r_sub + 1'b1;
      end
    end
  end

  assign o_idx = r_idx;
  assign o_sub = r_sub;
endmodule

// File: rtl/board_renderer.sv
// Tetris board renderer: shadow/active boards, cell trackers, 2-stage pixel pipeline, row flash.
module board_renderer
  import board_pkg::*;
#(
  parameter int COLS         = 10,
  parameter int ROWS         = 20,
  parameter int CELL_W       = 20,
  parameter int CELL_H       = 20,
  parameter int H_ORIGIN     = 220,
  parameter int V_ORIGIN     = 40,
  parameter int BORDER_W     = 4,
  parameter int LINE_W       = 1,
  parameter int FLASH_FRAMES = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  board_renderer_if.slave bus
);
  localparam int CW  = $clog2(COLS);
  localparam int RW  = $clog2(ROWS);
  localparam int SXW = $clog2(CELL_W + 1);
  localparam int SYW = $clog2(CELL_H + 1);
  localparam int FW  = $clog2(FLASH_FRAMES + 1);
  localparam int BX1 = H_ORIGIN + COLS * CELL_W;
  localparam int BY1 = V_ORIGIN + ROWS * CELL_H;

  int              w_x, w_y;
  logic [CW-1:0]   w_col;
  logic [RW-1:0]   w_row;
  logic [SXW-1:0]  w_sx;
  logic [SYW-1:0]  w_sy;
  logic            w_in_board, w_in_frame, w_grid, w_flash, w_copy;
  logic [2:0]      w_pidx;
  region_e         w_reg;
  logic [11:0]     w_rgb;

  logic [2:0]      r_shadow [ROWS][COLS];
  logic [2:0]      r_active [ROWS][COLS];
  logic            r_pending;
  logic [FW-1:0]   r_fcnt;
  logic            r_phase;
  region_e         r_s1_reg;
  logic [2:0]      r_s1_pidx;
  logic            r_s1_flash;
  logic [11:0]     r_rgb;

  assign w_x = int'(bus.counter_x);
  assign w_y = int'(bus.counter_y);

  // Column stops advancing on the last board pixel so the index never exceeds COLS-1.
  board_tracker #(.CELL(CELL_W), .IW(CW), .SW(SXW)) u_trk_x (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (bus.pix_en && w_x == H_ORIGIN - 1),
    .i_adv  (bus.pix_en && w_x >= H_ORIGIN && w_x < BX1 - 1),
    .o_idx  (w_col),
    .o_sub  (w_sx)
  );

  board_tracker #(.CELL(CELL_H), .IW(RW), .SW(SYW)) u_trk_y (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (bus.pix_en && w_x == 0 && w_y == V_ORIGIN),
    .i_adv  (bus.pix_en && w_x == 0 && w_y > V_ORIGIN && w_y < BY1),
    .o_idx  (w_row),
    .o_sub  (w_sy)
  );

  assign w_copy = bus.frame_start && (r_pending || bus.commit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) r_shadow[r][c] <= '0;
    end else if (bus.wr_en && 32'(bus.wr_col) < COLS && 32'(bus.wr_row) < ROWS) begin
      r_shadow[bus.wr_row][bus.wr_col] <= bus.wr_data;
    end
  end

  // Copy samples the shadow before any same-cycle write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) r_active[r][c] <= '0;
    end else if (w_copy) begin
      r_active <= r_shadow;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_pending <= 1'b0;
    else if (w_copy)     r_pending <= 1'b0;
    else if (bus.commit) r_pending <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fcnt  <= '0;
      r_phase <= 1'b0;
    end else if (bus.pix_en) begin
      if (bus.flash_mask == '0) begin
        r_fcnt  <= '0;
        r_phase <= 1'b0;
      end else if (bus.frame_start) begin
        if (r_fcnt == FW'(FLASH_FRAMES - 1)) begin
          r_fcnt  <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_fcnt <= r_fcnt + 1'b1;
        end
      end
    end
  end

  assign w_in_board = w_x >= H_ORIGIN && w_x < BX1 && w_y >= V_ORIGIN && w_y < BY1;
  assign w_in_frame = w_x >= H_ORIGIN - BORDER_W && w_x < BX1 + BORDER_W &&
                      w_y >= V_ORIGIN - BORDER_W && w_y < BY1 + BORDER_W;
  assign w_grid     = int'(w_sx) >= CELL_W - LINE_W || int'(w_sy) >= CELL_H - LINE_W;
  assign w_pidx     = w_in_board ? r_active[w_row][w_col] : 3'd0;
  assign w_flash    = w_in_board && bus.flash_mask[w_row] && r_phase;

  always_comb begin
    w_reg = BG;
    if (!bus.video_on)   w_reg = BLANK;
    else if (w_in_board) w_reg = w_grid ? GRID : CELL;
    else if (w_in_frame) w_reg = BORDER;
  end

  always_comb begin
    w_rgb = BLACK;
    case (r_s1_reg)
      BG:      w_rgb = WHITE;
      CELL:    w_rgb = pal_rgb(r_s1_pidx) ^ {12{r_s1_flash}};
      default: w_rgb = BLACK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_reg   <= BLANK;
      r_s1_pidx  <= '0;
      r_s1_flash <= 1'b0;
      r_rgb      <= BLACK;
    end else if (bus.pix_en) begin
      r_s1_reg   <= w_reg;
      r_s1_pidx  <= w_pidx;
      r_s1_flash <= w_flash;
      r_rgb      <= w_rgb;
    end
  end

  assign bus.commit_pending = r_pending;
  assign bus.r_red          = r_rgb[11:8];
  assign bus.r_green        = r_rgb[7:4];
  assign bus.r_blue         = r_rgb[3:0];
endmodule

// File: doc/board_renderer.md
Name: board_renderer

Overview:
- Parametrised successor to the fixed playfield pattern generator: draws a COLS x ROWS Tetris board of palette-coloured cells, with border, grid lines and background, from live VGA counters.
- Holds a shadow board written by game logic and an active board that is displayed. The shadow is committed to the active board only at frame start, so the display never tears.
- Registered 2-stage pixel pipeline. Row flash for line-clear animation.
- Sits between the VGA timing counters and the DAC pins.

Parameters:
- COLS, 10, board columns
- ROWS, 20, board rows
- CELL_W, 20, cell width in pixels (>= LINE_W+1)
- CELL_H, 20, cell height in pixels (>= LINE_W+1)
- H_ORIGIN, 220, x of first board pixel (>= BORDER_W+1)
- V_ORIGIN, 40, y of first board row (>= BORDER_W)
- BORDER_W, 4, border thickness around the board in pixels
- LINE_W, 1, grid-line thickness at the right/bottom of each cell; 0 = no grid
- FLASH_FRAMES, 8, frames per flash half-period

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pix_en  in  1  pixel strobe; counters are valid and advance by one pixel per strobe
- counter_x  in  10  horizontal counter
- counter_y  in  10  vertical counter
- video_on  in  1  active-video flag aligned to the counters
- frame_start  in  1  one-cycle pulse at first pixel of frame
- wr_en  in  1  shadow-board write strobe
- wr_col  in  clog2(COLS)  write column
- wr_row  in  clog2(ROWS)  write row
- wr_data  in  3  palette index; 0 = empty
- commit  in  1  request shadow->active copy at next frame_start
- flash_mask  in  ROWS  rows to flash
- commit_pending  out  1  commit requested, not yet applied
- r_red  out  4  red
- r_green  out  4  green
- r_blue  out  4  blue

Behaviour:
- Reset (async, rst_n low):
  - RGB = 0; commit_pending = 0.
  - Both boards all 0.
  - Flash frame counter = 0; flash phase = 0.
  - Col/row trackers = 0.
- All state other than the board write/commit logic advances only on clk edges with pix_en = 1.
- Column tracker (cell col + sub_x):
  - When counter_x == H_ORIGIN-1, load col = 0, sub_x = 0 for the next pixel.
  - Inside the board, sub_x increments; at CELL_W-1 it wraps to 0 and col increments.
  - No divider is used.
- Row tracker (cell row + sub_y): updated when counter_x == 0.
  - counter_y == V_ORIGIN: row = 0, sub_y = 0.
  - V_ORIGIN < counter_y < board bottom: sub_y increments with the same wrap rule.
- Region priority, per pixel, first match wins:
  - video_on = 0 -> black.
  - Inside board, and (sub_x >= CELL_W-LINE_W or sub_y >= CELL_H-LINE_W) -> grid colour, black.
  - Inside board -> palette[active[row][col]]; index 0 = field colour, yellow F,F,0.
  - Within BORDER_W of the board -> border colour, black.
  - Else -> background, white F,F,F.
- Flash: if flash_mask[row] and flash phase = 1, a cell pixel is output as bitwise-inverted RGB. Grid pixels are not inverted.
- Flash counter:
  - Counts frame_start pulses; at FLASH_FRAMES-1 it wraps to 0 and toggles the phase.
  - While flash_mask == 0, counter and phase are held at 0.
- Pipeline:
  - Stage 1 registers the region code, palette index and flash flag.
  - Stage 2 registers RGB.
  - Latency = 2 pix_en strobes from counter presentation to RGB.
- Writes:
  - Apply to the shadow board on any clk edge with wr_en, independent of pix_en.
  - wr_col >= COLS or wr_row >= ROWS is ignored.
- Commit:
  - commit sets commit_pending.
  - On frame_start with commit_pending, shadow is copied to active in one cycle and commit_pending clears.
  - commit and frame_start in the same cycle: the copy happens that cycle and pending clears.
  - wr_en in the copy cycle: active receives the pre-write shadow; the write lands in shadow only.
  - Repeated commit while pending has no extra effect.
- Reset mid-frame: outputs black immediately; trackers resync at the next H_ORIGIN-1 / V_ORIGIN.

Decomposition:
- Package board_pkg holds:
  - palette ROM constant: 8 x 12-bit; 0 = field yellow; 1-7 = cyan, blue, orange, yellow-dark, green, purple, red.
  - region enum: BG, BORDER, GRID, CELL, BLANK.
  - colour constants: WHITE, BLACK.
- One sub-module, board_tracker: the per-axis cell/sub-pixel counter, instantiated twice (x and y).

Test Plan:
- Reset, default parameters, full frame rendered -> pixel (0,0) = FFF; pixel (218,100) border = 000; (225,45) cell = FF0; (239,45) grid = 000; (440,100) = FFF.
- Write (col 3, row 2, data 1), no commit -> (285,85) stays FF0. Commit, then frame_start -> commit_pending falls that cycle and next frame (285,85) = 0FF. Grid pixel (299,85) = 000.
- Write with wr_col = 12 -> shadow unchanged. Commit and wr_en in the frame_start cycle -> active lacks the new write; a second commit shows it.
- flash_mask = 1<<19, write row 19 data 7 (F00), commit -> frames 0-7 show F00 at (225,425); frames 8-15 show 0FF; grid pixels unchanged.
- Check latency: step counter_x with pix_en gaps -> RGB changes exactly 2 strobes after the coordinate change. video_on = 0 -> 000 after 2 strobes.
- Async reset asserted mid-line -> RGB 000 without a clock edge. Release and run one frame -> boards empty, output matches the first scenario.
